// File: rtl/rand_pkg.sv
// Shared types and constants for the random-draw consumer.
package rand_pkg;

  // Draw flavour requested by the control logic.
  typedef enum logic {
    MODE_BERN = 1'b0,
    MODE_UNIF = 1'b1
  } mode_e;

  // Draw controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MASK = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Width of the per-draw random-word counter; holds up to 15.
  localparam int TRIES_W = 4;

  // Words a uniform draw may consume before it falls back.
  localparam int DEFAULT_MAX_TRIES = 8;

endpackage

// File: rtl/rand_draw_if.sv
// Request/response and random-word bus of the draw block.
// Handshake: a request transfers on a cycle with req_valid && req_ready,
// a response on a cycle with resp_valid && resp_ready; the producer holds
// valid and payload stable until that cycle. rand_valid is a one-cycle
// strobe with no back-pressure.
interface rand_draw_if;
  logic [31:0] rand_in;
  logic        rand_valid;
  logic        req_valid;
  logic        req_ready;
  logic        req_mode;
  logic [31:0] req_arg;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fallback;
  logic [3:0]  resp_tries;

  // Draw block side.
  modport slave (
    input  rand_in, rand_valid, req_valid, req_mode, req_arg, resp_ready,
    output req_ready, resp_valid, resp_data, resp_fallback, resp_tries
  );

  // Requester / generator side.
  modport master (
    output rand_in, rand_valid, req_valid, req_mode, req_arg, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_fallback, resp_tries
  );
endinterface

// File: rtl/rand_mask.sv
// Smallest all-ones mask covering bound-1, built by smearing the top set
// bit of bound-1 down through every lower position.
module rand_mask (
  input  logic [31:0] bound,
  output logic [31:0] mask
);

  logic [31:0] x;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] s4;
  logic [31:0] s8;

  // Cascaded shift-OR: after the 16-bit step every bit below the MSB is set.
  always_comb begin
    x    = bound - 32'd1;
    s1   = x  | (x  >> 1);
    s2   = s1 | (s1 >> 2);
    s4   = s2 | (s2 >> 4);
    s8   = s4 | (s4 >> 8);
    mask = s8 | (s8 >> 16);
  end

endmodule

// File: rtl/rand_draw.sv
// Converts raw 32-bit random words into Bernoulli decisions or unbiased
// uniform integers in [0, N) via mask-and-reject with a bounded retry count.
module rand_draw
  import rand_pkg::*;
#(
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic          clk,
  input  logic          rst,
  rand_draw_if.slave    bus,
  output state_e        dbg_state
);

  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [31:0]          arg_q, arg_d;
  logic [31:0]          mask_q, mask_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic [31:0]          data_q, data_d;
  logic                 fb_q, fb_d;
  logic                 rv_q, rv_d;

  logic [31:0]          smear;
  logic [31:0]          cand;
  logic [TRIES_W-1:0]   tries_inc;

  rand_mask u_mask (
    .bound (arg_q),
    .mask  (smear)
  );

  // Next-state and output-register computation for the draw controller.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    arg_d     = arg_q;
    mask_d    = mask_q;
    tries_d   = tries_q;
    data_d    = data_q;
    fb_d      = fb_q;
    rv_d      = rv_q;
    cand      = bus.rand_in & mask_q;
    tries_inc = tries_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          mode_d  = mode_e'(bus.req_mode);
          arg_d   = bus.req_arg;
          tries_d = '0;
          data_d  = '0;
          fb_d    = 1'b0;
          if (mode_e'(bus.req_mode) == MODE_UNIF) begin
            // N of 0 or 1 has only one possible answer: 0, no words needed.
            if (bus.req_arg <= 32'd1) begin
              state_d = ST_RESP;
              rv_d    = 1'b1;
            end else begin
              state_d = ST_MASK;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_MASK: begin
        mask_d  = smear;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.rand_valid) begin
          tries_d = tries_inc;
          if (mode_q == MODE_BERN) begin
            data_d  = {31'd0, (bus.rand_in < arg_q)};
            state_d = ST_RESP;
            rv_d    = 1'b1;
          end else if (cand < arg_q) begin
            data_d  = cand;
            state_d = ST_RESP;
            rv_d    = 1'b1;
          end else if (tries_inc == MAX_T) begin
            // Dropping the top mask bit always lands below N (slightly biased).
            data_d  = cand & (mask_q >> 1);
            fb_d    = 1'b1;
            state_d = ST_RESP;
            rv_d    = 1'b1;
          end
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight draw.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BERN;
      arg_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      data_q  <= '0;
      fb_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      arg_q   <= arg_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      data_q  <= data_d;
      fb_q    <= fb_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.resp_valid    = rv_q;
  assign bus.resp_data     = data_q;
  assign bus.resp_fallback = fb_q;
  assign bus.resp_tries    = tries_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_rand_draw.sv
// Directed bench for rand_draw: hand-computed vectors, immediate assertions.
module tb_rand_draw;
  import rand_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     errors;
  int     checks;

  rand_draw_if bus ();

  rand_draw #(.MAX_TRIES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle from IDLE.
  task automatic send_req(input logic mode, input logic [31:0] arg);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_arg   = arg;
    step();
    bus.req_valid = 1'b0;
  endtask

  // One-cycle random word strobe.
  task automatic strobe(input logic [31:0] word);
    bus.rand_in    = word;
    bus.rand_valid = 1'b1;
    step();
    bus.rand_valid = 1'b0;
  endtask

  // Check the pending response, then accept it.
  task automatic take_resp(input string tag, input logic [31:0] d, input logic fb,
                           input logic [3:0] t);
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_data"},  bus.resp_data, d);
    check({tag, "_fb"},    32'(bus.resp_fallback), 32'(fb));
    check({tag, "_tries"}, 32'(bus.resp_tries), 32'(t));
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    bus.rand_in    = '0;
    bus.rand_valid = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_mode   = 1'b0;
    bus.req_arg    = '0;
    bus.resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_fb", 32'(bus.resp_fallback), 32'd0);
    check("rst_tries", 32'(bus.resp_tries), 32'd0);

    // Bernoulli, threshold 0x80000000.
    send_req(1'b0, 32'h8000_0000);
    check("bern1_state", 32'(dbg_state), 32'(ST_WAIT));
    check("bern1_novalid", 32'(bus.resp_valid), 32'd0);
    strobe(32'h7FFF_FFFF);
    take_resp("bern1", 32'd1, 1'b0, 4'd1);

    send_req(1'b0, 32'h8000_0000);
    strobe(32'h8000_0000);
    take_resp("bern2", 32'd0, 1'b0, 4'd1);

    send_req(1'b0, 32'hFFFF_FFFF);
    strobe(32'hFFFF_FFFF);
    take_resp("bern_max_top", 32'd0, 1'b0, 4'd1);

    send_req(1'b0, 32'hFFFF_FFFF);
    strobe(32'hFFFF_FFFE);
    take_resp("bern_max", 32'd1, 1'b0, 4'd1);

    send_req(1'b0, 32'h0000_0000);
    strobe(32'h0000_0000);
    take_resp("bern_zero", 32'd0, 1'b0, 4'd1);

    // Uniform N=10: reject 0xC, accept low nibble 7.
    send_req(1'b1, 32'd10);
    check("u10_mask_state", 32'(dbg_state), 32'(ST_MASK));
    step();
    check("u10_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    strobe(32'h0000_000C);
    check("u10_reject", 32'(bus.resp_valid), 32'd0);
    strobe(32'h1234_5677);
    take_resp("u10", 32'd7, 1'b0, 4'd2);

    // Uniform N=9: eight rejects, then fallback 0xF & 0x7.
    send_req(1'b1, 32'd9);
    step();
    for (int i = 0; i < 8; i++) begin
      check("u9_early", 32'(bus.resp_valid), 32'd0);
      strobe((32'(i) << 8) | 32'h0000_00AF);
    end
    take_resp("u9_fallback", 32'd7, 1'b1, 4'd8);

    // Uniform N=0xFFFFFFFF: full mask, all-ones word rejected.
    send_req(1'b1, 32'hFFFF_FFFF);
    step();
    strobe(32'hFFFF_FFFF);
    check("umax_reject", 32'(bus.resp_valid), 32'd0);
    strobe(32'h1234_5678);
    take_resp("umax", 32'h1234_5678, 1'b0, 4'd2);

    // Degenerate uniform N=0 and N=1 with a coincident strobe.
    for (int n = 0; n < 2; n++) begin
      bus.rand_in    = 32'h0000_0003;
      bus.rand_valid = 1'b1;
      send_req(1'b1, 32'(n));
      check("udeg_valid_c1", 32'(bus.resp_valid), 32'd1);
      strobe(32'h0000_0005);
      take_resp("udeg", 32'd0, 1'b0, 4'd0);
    end

    // Backpressure: response held while strobes arrive.
    send_req(1'b0, 32'h0000_0010);
    strobe(32'h0000_0005);
    for (int i = 0; i < 5; i++) begin
      bus.rand_in    = 32'hFFFF_FFFF;
      bus.rand_valid = 1'b1;
      step();
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_data", bus.resp_data, 32'd1);
      check("bp_fb", 32'(bus.resp_fallback), 32'd0);
      check("bp_tries", 32'(bus.resp_tries), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rand_valid = 1'b0;
    take_resp("bp", 32'd1, 1'b0, 4'd1);

    // Words strobed in IDLE and MASK must not be consumed.
    bus.rand_in    = 32'h0000_0002;
    bus.rand_valid = 1'b1;
    send_req(1'b1, 32'd10);
    strobe(32'h0000_0003);
    strobe(32'h0000_0005);
    take_resp("drop", 32'd5, 1'b0, 4'd1);

    // Reset during WAIT with three words consumed.
    send_req(1'b1, 32'd9);
    step();
    strobe(32'h0000_000F);
    strobe(32'h0000_000F);
    strobe(32'h0000_000F);
    check("rw_state", 32'(dbg_state), 32'(ST_WAIT));
    check("rw_tries", 32'(bus.resp_tries), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("rw_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rw_req_ready", 32'(bus.req_ready), 32'd1);
    check("rw_tries_clr", 32'(bus.resp_tries), 32'd0);
    send_req(1'b0, 32'h8000_0000);
    strobe(32'h0000_0001);
    take_resp("after_rst", 32'd1, 1'b0, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
